// File: rtl/lcd_timing_sequencer_if.sv
// Pixel-source and panel-pin bundle for lcd_timing_sequencer.
// slave = sequencer side, master = upstream pixel source / panel observer.
interface lcd_timing_sequencer_if;
   logic        i_en;
   logic [15:0] i_pix_rgb;
   logic        i_pix_valid;
   logic        i_clr_underrun;
   logic        o_pix_req;
   logic [4:0]  o_lcd_r;
   logic [5:0]  o_lcd_g;
   logic [4:0]  o_lcd_b;
   logic        o_de;
   logic        o_hsync;
   logic        o_vsync;
   logic [9:0]  o_x;
   logic [9:0]  o_y;
   logic        o_frame_start;
   logic        o_busy;
   logic        o_underrun;

   modport slave (
      input  i_en, i_pix_rgb, i_pix_valid, i_clr_underrun,
      output o_pix_req, o_lcd_r, o_lcd_g, o_lcd_b, o_de, o_hsync, o_vsync,
             o_x, o_y, o_frame_start, o_busy, o_underrun
   );

   modport master (
      output i_en, i_pix_rgb, i_pix_valid, i_clr_underrun,
      input  o_pix_req, o_lcd_r, o_lcd_g, o_lcd_b, o_de, o_hsync, o_vsync,
             o_x, o_y, o_frame_start, o_busy, o_underrun
   );
endinterface

// File: rtl/lcd_timing_sequencer.sv
// RGB565 LCD timing sequencer: H/V porch counters, pixel prefetch, registered panel pins.
// Optional build macro LCD_UNDERRUN_BLANK_EN: underrun slots drive black instead of repeating.
module lcd_timing_sequencer #(
   parameter int H_ACTIVE = 800,
   parameter int H_FP     = 210,
   parameter int H_SYNC   = 1,
   parameter int H_BP     = 46,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 22,
   parameter int V_SYNC   = 1,
   parameter int V_BP     = 23
) (
   input logic                    i_clk,
   input logic                    i_rst,
   lcd_timing_sequencer_if.slave  bus
);

   localparam int H_TOT       = H_SYNC + H_BP + H_ACTIVE + H_FP;
   localparam int V_TOT       = V_SYNC + V_BP + V_ACTIVE + V_FP;
   localparam int H_ACT_START = H_SYNC + H_BP;
   localparam int H_ACT_END   = H_ACT_START + H_ACTIVE;
   localparam int V_ACT_START = V_SYNC + V_BP;
   localparam int V_ACT_END   = V_ACT_START + V_ACTIVE;

   typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

   state_t      state;
   logic [10:0] h_cnt;
   logic [10:0] v_cnt;

   logic        running;
   logic        h_act;
   logic        v_act;
   logic        in_hsync;
   logic        in_vsync;
   logic        h_last;
   logic        v_last;
   logic        pix_req;

   logic        de_q;
   logic        hsync_q;
   logic        vsync_q;
   logic [9:0]  x_q;
   logic [9:0]  y_q;
   logic        frame_start_q;
   logic [15:0] rgb_q;
   logic [15:0] rgb_hold;
   logic        underrun_q;

   assign running  = (state != IDLE);
   assign h_act    = (h_cnt >= 11'(H_ACT_START)) && (h_cnt < 11'(H_ACT_END));
   assign v_act    = (v_cnt >= 11'(V_ACT_START)) && (v_cnt < 11'(V_ACT_END));
   assign in_hsync = (h_cnt < 11'(H_SYNC));
   assign in_vsync = (v_cnt < 11'(V_SYNC));
   assign h_last   = (h_cnt == 11'(H_TOT - 1));
   assign v_last   = (v_cnt == 11'(V_TOT - 1));
   // Request is decoded from registers only, one cycle ahead of the registered DE.
   assign pix_req  = running && h_act && v_act;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state <= IDLE;
         h_cnt <= '0;
         v_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.i_en) state <= RUN;
            end
            RUN, STOP: begin
               // Stopping only takes effect at the frame boundary; until then i_en toggles RUN/STOP.
               if (h_last && v_last) state <= bus.i_en ? RUN : IDLE;
               else                  state <= bus.i_en ? RUN : STOP;
               if (h_last) begin
                  h_cnt <= '0;
                  v_cnt <= v_last ? 11'd0 : v_cnt + 11'd1;
               end else begin
                  h_cnt <= h_cnt + 11'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         de_q          <= 1'b0;
         hsync_q       <= 1'b1;
         vsync_q       <= 1'b1;
         x_q           <= '0;
         y_q           <= '0;
         frame_start_q <= 1'b0;
         rgb_q         <= '0;
         rgb_hold      <= '0;
         underrun_q    <= 1'b0;
      end else begin
         de_q          <= pix_req;
         hsync_q       <= ~(running && in_hsync);
         vsync_q       <= ~(running && in_vsync);
         x_q           <= pix_req ? 10'(h_cnt - 11'(H_ACT_START)) : 10'd0;
         y_q           <= pix_req ? 10'(v_cnt - 11'(V_ACT_START)) : 10'd0;
         frame_start_q <= running && (h_cnt == 11'd0) && (v_cnt == 11'd0);

         if (pix_req && bus.i_pix_valid) begin
            rgb_q    <= bus.i_pix_rgb;
            rgb_hold <= bus.i_pix_rgb;
         end else if (pix_req) begin
`ifdef LCD_UNDERRUN_BLANK_EN
            rgb_q <= '0;
`else
            rgb_q <= rgb_hold;
`endif
         end else begin
            rgb_q <= '0;
         end

         // Set has priority over clear so a simultaneous underrun is never lost.
         if (pix_req && !bus.i_pix_valid) underrun_q <= 1'b1;
         else if (bus.i_clr_underrun)     underrun_q <= 1'b0;
      end
   end

   assign bus.o_pix_req     = pix_req;
   assign bus.o_lcd_r       = rgb_q[15:11];
   assign bus.o_lcd_g       = rgb_q[10:5];
   assign bus.o_lcd_b       = rgb_q[4:0];
   assign bus.o_de          = de_q;
   assign bus.o_hsync       = hsync_q;
   assign bus.o_vsync       = vsync_q;
   assign bus.o_x           = x_q;
   assign bus.o_y           = y_q;
   assign bus.o_frame_start = frame_start_q;
   assign bus.o_busy        = running;
   assign bus.o_underrun    = underrun_q;

endmodule

// File: tb/tb_lcd_timing_sequencer.sv
// Scoreboard bench for lcd_timing_sequencer on a reduced 9x6 raster (54 clocks per frame).
// Model tracks a busy flag and a linear position within the frame.
module tb_lcd_timing_sequencer;

   localparam int HA = 4, HF = 2, HS = 1, HB = 2;
   localparam int VA = 3, VF = 1, VS = 1, VB = 1;
   localparam int HT = HS + HB + HA + HF;
   localparam int VT = VS + VB + VA + VF;
   localparam int FRAME = HT * VT;
`ifdef LCD_UNDERRUN_BLANK_EN
   localparam bit BLANK = 1'b1;
`else
   localparam bit BLANK = 1'b0;
`endif

   typedef struct packed {
      logic        req;
      logic [15:0] rgb;
      logic        de;
      logic        hs;
      logic        vs;
      logic [9:0]  x;
      logic [9:0]  y;
      logic        fs;
      logic        busy;
      logic        und;
   } obs_t;

   logic clk = 1'b0;
   logic rst;
   lcd_timing_sequencer_if bus ();

   lcd_timing_sequencer #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
   ) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int   checks = 0;
   int   errors = 0;
   int   de_count = 0;
   int   fs_count = 0;
   obs_t exp_q[$];

   bit          m_busy = 1'b0;
   int          m_pos = 0;
   logic        m_und = 1'b0;
   logic [15:0] m_hold = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic bit in_active(input int pos);
      int h = pos % HT;
      int v = pos / HT;
      return (h >= HS + HB) && (h < HS + HB + HA) && (v >= VS + VB) && (v < VS + VB + VA);
   endfunction

   // Expected outputs after the coming edge, from the pre-edge model position and inputs.
   task automatic model_step(input logic en, input logic r, input logic valid,
                             input logic clr, input logic [15:0] rgb);
      obs_t e;
      int   h, v;
      bit   req;
      e   = '0;
      h   = m_pos % HT;
      v   = m_pos / HT;
      req = m_busy && in_active(m_pos);
      if (r) begin
         e.hs   = 1'b1;
         e.vs   = 1'b1;
         m_busy = 1'b0;
         m_pos  = 0;
         m_und  = 1'b0;
         m_hold = '0;
      end else begin
         e.de = req;
         e.x  = req ? 10'(h - (HS + HB)) : 10'd0;
         e.y  = req ? 10'(v - (VS + VB)) : 10'd0;
         e.hs = !(m_busy && h < HS);
         e.vs = !(m_busy && v < VS);
         e.fs = m_busy && (m_pos == 0);
         if (req && valid) begin
            e.rgb  = rgb;
            m_hold = rgb;
         end else if (req) begin
            e.rgb = BLANK ? 16'd0 : m_hold;
         end
         if (req && !valid) m_und = 1'b1;
         else if (clr)      m_und = 1'b0;
         e.und = m_und;
         if (!m_busy || m_pos == FRAME - 1) begin
            m_busy = en;
            m_pos  = 0;
         end else begin
            m_pos++;
         end
      end
      e.busy = m_busy;
      e.req  = m_busy && in_active(m_pos);
      exp_q.push_back(e);
   endtask

   task automatic step(input logic en, input logic r, input logic valid,
                       input logic clr, input logic [15:0] rgb);
      rst                = r;
      bus.i_en           = en;
      bus.i_pix_valid    = valid;
      bus.i_clr_underrun = clr;
      bus.i_pix_rgb      = rgb;
      model_step(en, r, valid, clr, rgb);
      @(posedge clk);
      #2;
   endtask

   initial begin : monitor
      obs_t e, a;
      int   cyc = 0;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (exp_q.size() > 0) begin
            e      = exp_q.pop_front();
            a.req  = bus.o_pix_req;
            a.rgb  = {bus.o_lcd_r, bus.o_lcd_g, bus.o_lcd_b};
            a.de   = bus.o_de;
            a.hs   = bus.o_hsync;
            a.vs   = bus.o_vsync;
            a.x    = bus.o_x;
            a.y    = bus.o_y;
            a.fs   = bus.o_frame_start;
            a.busy = bus.o_busy;
            a.und  = bus.o_underrun;
            check($sformatf("outputs@%0d", cyc), 64'(a), 64'(e));
            if (bus.o_de === 1'b1)          de_count++;
            if (bus.o_frame_start === 1'b1) fs_count++;
         end
      end
   end

   initial begin : driver
      logic [15:0] pix = 16'h0100;

      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);

      // Idle with the panel disabled: no frames may start.
      fs_count = 0;
      for (int i = 0; i < 100; i++) step(1'b0, 1'b0, 1'($urandom), 1'b0, 16'($urandom));
      check("idle_frame_starts", 64'(fs_count), 64'd0);
      check("idle_busy", 64'(bus.o_busy), 64'd0);

      // Three back-to-back frames with an always-valid incrementing source, then stop at the boundary.
      de_count = 0;
      fs_count = 0;
      for (int i = 0; i < 1 + 3 * FRAME - 1; i++) begin
         step(1'b1, 1'b0, 1'b1, 1'b0, pix);
         pix++;
      end
      for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b1, 1'b0, pix);
      check("three_frame_de_cycles", 64'(de_count), 64'(3 * HA * VA));
      check("three_frame_starts", 64'(fs_count), 64'd3);
      check("stopped_busy", 64'(bus.o_busy), 64'd0);

      // Mid-frame stop, re-raise during STOP, then stop again and let the frame drain.
      for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 16'($urandom));
      for (int i = 0; i < 15; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 16'($urandom));
      for (int i = 0; i < 30; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 16'($urandom));
      for (int i = 0; i < 2 * FRAME; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 16'($urandom));

      // Randomized traffic: underruns, clears (sometimes coincident), en drops, rare resets.
      for (int i = 0; i < 2000; i++)
         step(($urandom % 16) != 0, ($urandom % 400) == 0, ($urandom % 6) != 0,
              ($urandom % 7) == 0, 16'($urandom));

      for (int i = 0; i < 2 * FRAME; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 16'($urandom));
      check("final_busy", 64'(bus.o_busy), 64'd0);
      check("final_underrun_cleared", 64'(bus.o_underrun), 64'd0);
      check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
